// File: rtl/cpu_uart_pkg.sv
// Shared constants and types for the CPU-bus UART transmitter.
package cpu_uart_pkg;

  localparam logic [1:0] OFS_DATA   = 2'd0;
  localparam logic [1:0] OFS_STATUS = 2'd1;
  localparam logic [1:0] OFS_DIV_LO = 2'd2;
  localparam logic [1:0] OFS_DIV_HI = 2'd3;

  localparam int unsigned ST_FULL  = 0;
  localparam int unsigned ST_EMPTY = 1;
  localparam int unsigned ST_BUSY  = 2;
  localparam int unsigned ST_OVF   = 3;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;

endpackage

// File: rtl/byte_fifo.sv
// Byte-wide FIFO with a separately tracked count; head entry is visible on rdata
// combinationally.
module byte_fifo #(
  parameter int unsigned DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic [7:0]                 wdata,
  output logic [7:0]                 rdata,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [CW-1:0] count_q, count_d;
  logic          push_ok, pop_ok;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign pop_ok  = pop & ~empty;
  // A push into a full FIFO is legal when the head leaves in the same cycle.
  assign push_ok = push & (~full | pop_ok);
  assign rdata   = mem_q[rptr_q];
  assign count   = count_q;

  always_comb begin
    count_d = count_q;
    unique case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push_ok) wptr_q <= wptr_q + 1'b1;
      if (pop_ok)  rptr_q <= rptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wptr_q] <= wdata;
  end

endmodule

// File: rtl/cpu_uart_tx.sv
// Memory-mapped 8N1 UART transmitter on the 6502 bus: register decode, baud divisor,
// TX FIFO and the serialising FSM.
module cpu_uart_tx
  import cpu_uart_pkg::*;
#(
  parameter logic [15:0] BASE        = 16'h6000,
  parameter int unsigned DEPTH       = 8,
  parameter logic [15:0] DEFAULT_DIV = 16'd433
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [15:0]            adr_bus,
  input  logic [7:0]             cpu_wdata,
  input  logic                   RW,
  output logic [7:0]             cpu_rdata,
  output logic                   cpu_sel,
  output logic                   txd,
  output logic                   tx_irq,
  output logic [$clog2(DEPTH):0] dbg_fifo_count
);

  logic       hit, wr_en, rd_en;
  logic [1:0] ofs;
  logic       push_req, push_ok, pop;
  logic       fifo_full, fifo_empty;
  logic [7:0] fifo_rdata;
  logic       busy;
  logic [7:0] status;

  logic [15:0] div_q, div_d;
  logic        ovf_q, ovf_d;
  logic [7:0]  rdata_q, rdata_d;
  logic        sel_q;

  tx_state_t   state_q, state_d;
  logic [7:0]  shreg_q, shreg_d;
  logic [15:0] timer_q, timer_d;
  logic [15:0] div_lat_q, div_lat_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic        txd_q, txd_d;
  logic        tick;

  assign hit      = (adr_bus[15:2] == BASE[15:2]);
  assign ofs      = adr_bus[1:0];
  assign wr_en    = hit & ~RW;
  assign rd_en    = hit & RW;
  assign push_req = wr_en & (ofs == OFS_DATA);
  assign push_ok  = push_req & (~fifo_full | pop);
  assign busy     = (state_q != IDLE);
  assign tick     = (timer_q == '0);

  byte_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push_ok),
    .pop   (pop),
    .wdata (cpu_wdata),
    .rdata (fifo_rdata),
    .count (dbg_fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    status         = '0;
    status[ST_OVF]   = ovf_q;
    status[ST_BUSY]  = busy;
    status[ST_EMPTY] = fifo_empty;
    status[ST_FULL]  = fifo_full;
  end

  // Bus side: divisor, sticky overflow and registered read data.
  always_comb begin
    div_d   = div_q;
    ovf_d   = ovf_q;
    rdata_d = 8'h00;
    if (wr_en && ofs == OFS_DIV_LO) div_d[7:0]  = cpu_wdata;
    if (wr_en && ofs == OFS_DIV_HI) div_d[15:8] = cpu_wdata;
    if (push_req && !push_ok) begin
      ovf_d = 1'b1;
    end else if (wr_en && ofs == OFS_STATUS && cpu_wdata[ST_OVF]) begin
      ovf_d = 1'b0;
    end
    if (rd_en) begin
      case (ofs)
        OFS_STATUS: rdata_d = status;
        OFS_DIV_LO: rdata_d = div_q[7:0];
        OFS_DIV_HI: rdata_d = div_q[15:8];
        default:    rdata_d = 8'h00;
      endcase
    end
  end

  // Serialiser; the divisor is latched per frame so mid-frame writes wait a frame.
  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    timer_d   = timer_q;
    div_lat_d = div_lat_q;
    bit_cnt_d = bit_cnt_q;
    pop       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop       = 1'b1;
          shreg_d   = fifo_rdata;
          timer_d   = div_q;
          div_lat_d = div_q;
          state_d   = START;
        end
      end
      START: begin
        if (tick) begin
          timer_d   = div_lat_q;
          bit_cnt_d = 3'd0;
          state_d   = DATA;
        end else begin
          timer_d = timer_q - 16'd1;
        end
      end
      DATA: begin
        if (tick) begin
          shreg_d   = {1'b0, shreg_q[7:1]};
          timer_d   = div_lat_q;
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = STOP;
        end else begin
          timer_d = timer_q - 16'd1;
        end
      end
      STOP: begin
        if (tick) begin
          if (!fifo_empty) begin
            pop       = 1'b1;
            shreg_d   = fifo_rdata;
            timer_d   = div_q;
            div_lat_d = div_q;
            state_d   = START;
          end else begin
            state_d = IDLE;
          end
        end else begin
          timer_d = timer_q - 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    case (state_d)
      START:   txd_d = 1'b0;
      DATA:    txd_d = shreg_d[0];
      default: txd_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_q     <= DEFAULT_DIV;
      ovf_q     <= 1'b0;
      rdata_q   <= 8'h00;
      sel_q     <= 1'b0;
      state_q   <= IDLE;
      shreg_q   <= 8'h00;
      timer_q   <= '0;
      div_lat_q <= DEFAULT_DIV;
      bit_cnt_q <= 3'd0;
      txd_q     <= 1'b1;
    end else begin
      div_q     <= div_d;
      ovf_q     <= ovf_d;
      rdata_q   <= rdata_d;
      sel_q     <= rd_en;
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      timer_q   <= timer_d;
      div_lat_q <= div_lat_d;
      bit_cnt_q <= bit_cnt_d;
      txd_q     <= txd_d;
    end
  end

  assign cpu_rdata = rdata_q;
  assign cpu_sel   = sel_q;
  assign txd       = txd_q;
  assign tx_irq    = fifo_empty & ~busy;

endmodule

// File: tb/tb_cpu_uart_tx.sv
// Directed bench for cpu_uart_tx: register-access table plus hand-built frame sequences.
module tb_cpu_uart_tx;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] adr_bus;
  logic [7:0]  cpu_wdata;
  logic        RW;
  logic [7:0]  cpu_rdata;
  logic        cpu_sel;
  logic        txd;
  logic        tx_irq;
  logic [3:0]  dbg_fifo_count;

  int checks = 0;
  int errors = 0;

  cpu_uart_tx #(
    .BASE        (16'h6000),
    .DEPTH       (8),
    .DEFAULT_DIV (16'd433)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .adr_bus        (adr_bus),
    .cpu_wdata      (cpu_wdata),
    .RW             (RW),
    .cpu_rdata      (cpu_rdata),
    .cpu_sel        (cpu_sel),
    .txd            (txd),
    .tx_irq         (tx_irq),
    .dbg_fifo_count (dbg_fifo_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] adr;
    logic        rw;
    logic [7:0]  wdata;
    logic [7:0]  exp_rdata;
    logic        exp_sel;
  } vec_t;

  vec_t tbl[20];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Inputs change on negedge like the CPU; each call spans exactly one posedge.
  task automatic wr(input logic [15:0] a, input logic [7:0] d);
    adr_bus = a; RW = 1'b0; cpu_wdata = d;
    @(negedge clk);
    adr_bus = 16'h0000; RW = 1'b1;
  endtask

  task automatic rd_check(input string name, input logic [15:0] a, input logic [7:0] exp);
    adr_bus = a; RW = 1'b1;
    @(negedge clk);
    check({name, " sel"}, cpu_sel, 1'b1);
    check(name, cpu_rdata, exp);
    adr_bus = 16'h0000;
  endtask

  task automatic wait_idle(input string name, input int limit);
    int n = 0;
    while (!tx_irq && n < limit) begin
      @(negedge clk);
      n++;
    end
    check(name, tx_irq, 1'b1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [9:0] frame;
    logic [7:0] trace [400];
    int bad, n, k;
    logic s40, s41;

    tbl[0]  = '{16'h6001, 1'b1, 8'h00, 8'h02, 1'b1};
    tbl[1]  = '{16'h6002, 1'b1, 8'h00, 8'hB1, 1'b1};
    tbl[2]  = '{16'h6003, 1'b1, 8'h00, 8'h01, 1'b1};
    tbl[3]  = '{16'h6000, 1'b1, 8'h00, 8'h00, 1'b1};
    tbl[4]  = '{16'h6004, 1'b1, 8'h00, 8'h00, 1'b0};
    tbl[5]  = '{16'h5FFF, 1'b1, 8'h00, 8'h00, 1'b0};
    tbl[6]  = '{16'h6006, 1'b0, 8'h55, 8'h00, 1'b0};
    tbl[7]  = '{16'h6002, 1'b1, 8'h00, 8'hB1, 1'b1};
    tbl[8]  = '{16'h6004, 1'b0, 8'hAA, 8'h00, 1'b0};
    tbl[9]  = '{16'h6001, 1'b1, 8'h00, 8'h02, 1'b1};
    tbl[10] = '{16'h6002, 1'b0, 8'h34, 8'h00, 1'b0};
    tbl[11] = '{16'h6003, 1'b0, 8'h12, 8'h00, 1'b0};
    tbl[12] = '{16'h6002, 1'b1, 8'h00, 8'h34, 1'b1};
    tbl[13] = '{16'h6003, 1'b1, 8'h00, 8'h12, 1'b1};
    tbl[14] = '{16'h6001, 1'b0, 8'hF7, 8'h00, 1'b0};
    tbl[15] = '{16'h6001, 1'b1, 8'h00, 8'h02, 1'b1};
    tbl[16] = '{16'h6002, 1'b0, 8'h03, 8'h00, 1'b0};
    tbl[17] = '{16'h6003, 1'b0, 8'h00, 8'h00, 1'b0};
    tbl[18] = '{16'h6002, 1'b1, 8'h00, 8'h03, 1'b1};
    tbl[19] = '{16'h6003, 1'b1, 8'h00, 8'h00, 1'b1};

    reset = 1'b1; adr_bus = 16'h0000; cpu_wdata = 8'h00; RW = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    check("reset txd", txd, 1'b1);
    check("reset tx_irq", tx_irq, 1'b1);
    check("reset cpu_sel", cpu_sel, 1'b0);
    check("reset cpu_rdata", cpu_rdata, 8'h00);
    check("reset count", dbg_fifo_count, 4'd0);

    // Register map, decode window and divisor readback; ends with DIV = 3.
    for (int i = 0; i < 20; i++) begin
      adr_bus = tbl[i].adr; RW = tbl[i].rw; cpu_wdata = tbl[i].wdata;
      @(negedge clk);
      if (tbl[i].rw) begin
        check($sformatf("tbl[%0d] sel", i), cpu_sel, tbl[i].exp_sel);
        check($sformatf("tbl[%0d] rdata", i), cpu_rdata, tbl[i].exp_rdata);
      end
      adr_bus = 16'h0000; RW = 1'b1;
    end
    check("table idle txd", txd, 1'b1);
    check("table idle irq", tx_irq, 1'b1);

    // Single frame 0xA5 at 4 clocks per bit.
    frame = {1'b1, 8'hA5, 1'b0};
    wr(16'h6000, 8'hA5);
    for (int i = 0; i < 10; i++) begin
      bad = 0;
      for (int c = 0; c < 4; c++) begin
        @(negedge clk);
        if (txd !== frame[i]) bad++;
      end
      check($sformatf("A5 bit %0d bad samples", i), bad, 0);
    end
    check("A5 irq in stop", tx_irq, 1'b0);
    @(negedge clk);
    check("A5 irq after frame", tx_irq, 1'b1);
    check("A5 txd idle", txd, 1'b1);

    // DIV = 0: fill past DEPTH, overflow, clear.
    wr(16'h6002, 8'h00);
    for (int b = 0; b < 9; b++) wr(16'h6000, 8'(b));
    check("9 bytes count", dbg_fifo_count, 4'd8);
    wr(16'h6000, 8'h09);
    check("10th byte dropped", dbg_fifo_count, 4'd8);
    rd_check("status ovf", 16'h6001, 8'h0D);
    wr(16'h6001, 8'h08);
    rd_check("status ovf cleared", 16'h6001, 8'h04);
    wait_idle("drain 9", 1000);
    rd_check("status drained", 16'h6001, 8'h02);

    // Back-to-back frames at DIV = 3.
    wr(16'h6002, 8'h03);
    wr(16'h6000, 8'h3C);
    wr(16'h6000, 8'hC3);
    n = 0; s40 = 1'bx; s41 = 1'bx;
    while (!tx_irq && n < 500) begin
      n++;
      if (n == 40) s40 = txd;
      if (n == 41) s41 = txd;
      @(negedge clk);
    end
    check("two frames length", n, 80);
    check("first stop bit", s40, 1'b1);
    check("second start no gap", s41, 1'b0);

    // Divisor change mid-frame applies to the following frame only.
    wr(16'h6000, 8'h01);
    wr(16'h6000, 8'h01);
    wr(16'h6002, 8'h07);
    k = 0;
    while (!tx_irq && k < 400) begin
      trace[k] = {7'd0, txd};
      @(negedge clk);
      k++;
    end
    check("div change total", k, 119);
    check("f1 start end", trace[2], 8'd0);
    check("f1 bit0 first", trace[3], 8'd1);
    check("f1 bit0 last", trace[6], 8'd1);
    check("f1 bit1", trace[7], 8'd0);
    check("f1 stop", trace[38], 8'd1);
    check("f2 start first", trace[39], 8'd0);
    check("f2 start last", trace[46], 8'd0);
    check("f2 bit0 first", trace[47], 8'd1);
    check("f2 bit0 last", trace[54], 8'd1);
    check("f2 bit1", trace[55], 8'd0);

    // Reset during DATA discards the frame and the queue.
    wr(16'h6000, 8'h55);
    wr(16'h6000, 8'hAA);
    repeat (20) @(negedge clk);
    check("pre-reset queued", dbg_fifo_count, 4'd1);
    check("pre-reset busy", tx_irq, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("post-reset txd", txd, 1'b1);
    check("post-reset count", dbg_fifo_count, 4'd0);
    check("post-reset irq", tx_irq, 1'b1);
    rd_check("post-reset status", 16'h6001, 8'h02);
    rd_check("post-reset div lo", 16'h6002, 8'hB1);
    rd_check("post-reset div hi", 16'h6003, 8'h01);
    repeat (5) @(negedge clk);
    check("post-reset stays idle", txd, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
